// File: rtl/udma_i2s_pkg.sv
// Shared types and sizing helpers for the I2S RX stream arbiter.
package udma_i2s_pkg;

    localparam int unsigned NUM_CHANNELS_DEFAULT = 2;

    // Channel-ID width, never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 2) ? int'($clog2(n)) : 1;
    endfunction

    localparam int unsigned ID_W = id_width(NUM_CHANNELS_DEFAULT);

    typedef enum logic {
        ARB_RR     = 1'b0,
        ARB_STRICT = 1'b1
    } arb_mode_e;

endpackage

// File: rtl/udma_i2s_rr_pick.sv
// First set bit of req at or after start, wrapping modulo N.
module udma_i2s_rr_pick
    import udma_i2s_pkg::*;
#(
    parameter int unsigned N  = 2,
    localparam int unsigned IW = id_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic          found_c,
    output logic [IW-1:0] idx_c
);

    logic [IW-1:0] cand [N];

    always_comb begin
        found_c = 1'b0;
        idx_c   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand[i] = IW'((32'(start) + i) % N);
            if (!found_c && req[cand[i]]) begin
                found_c = 1'b1;
                idx_c   = cand[i];
            end
        end
    end

endmodule

// File: rtl/udma_i2s_rx_arbiter.sv
// Merges the per-channel I2S RX sample streams onto the single uDMA RX stream,
// with round-robin or strict in-order scheduling and a strict-mode starvation timeout.
module udma_i2s_rx_arbiter
    import udma_i2s_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS = 2,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned TIMEOUT_W    = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 clr_i,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]   ch_data_i,
    input  logic [NUM_CHANNELS-1:0]              ch_valid_i,
    output logic [NUM_CHANNELS-1:0]              ch_ready_o,
    output logic [DATA_WIDTH-1:0]                data_o,
    output logic                                 valid_o,
    input  logic                                 ready_i,
    output logic [id_width(NUM_CHANNELS)-1:0]    ch_id_o,
    input  logic [NUM_CHANNELS-1:0]              cfg_ch_en_i,
    input  logic                                 cfg_strict_i,
    input  logic                                 cfg_tag_en_i,
    input  logic [TIMEOUT_W-1:0]                 cfg_timeout_i,
    output logic [NUM_CHANNELS-1:0]              err_o,
    input  logic [NUM_CHANNELS-1:0]              err_clr_i
);

    localparam int unsigned        CH_ID_W = id_width(NUM_CHANNELS);
    localparam logic [CH_ID_W-1:0] LAST_CH = CH_ID_W'(NUM_CHANNELS - 1);

    arb_mode_e               mode;
    logic                    soft_rst;
    logic                    can_load;
    logic                    load;
    logic                    grant_any;
    logic [CH_ID_W-1:0]      grant_idx;
    logic [CH_ID_W-1:0]      start_idx;
    logic [NUM_CHANNELS-1:0] eligible;
    logic                    rr_found;
    logic [CH_ID_W-1:0]      rr_idx;
    logic                    en_found;
    logic [CH_ID_W-1:0]      en_idx;
    logic [DATA_WIDTH-1:0]   ch_data [NUM_CHANNELS];

    logic [CH_ID_W-1:0]      ptr_q, ptr_d;
    logic [TIMEOUT_W-1:0]    cnt_q, cnt_d;
    logic                    valid_d;
    logic [DATA_WIDTH-1:0]   data_d;
    logic [CH_ID_W-1:0]      ch_id_d;
    logic [NUM_CHANNELS-1:0] err_d;

    assign soft_rst  = rst_i | clr_i;
    assign mode      = cfg_strict_i ? ARB_STRICT : ARB_RR;
    assign eligible  = ch_valid_i & cfg_ch_en_i;
    assign start_idx = (ptr_q == LAST_CH) ? '0 : ptr_q + CH_ID_W'(1);
    assign can_load  = !valid_o || ready_i;

    always_comb begin
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            ch_data[i] = ch_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Round-robin grant search over eligible channels.
    udma_i2s_rr_pick #(.N(NUM_CHANNELS)) u_rr_pick (
        .req     (eligible),
        .start   (start_idx),
        .found_c (rr_found),
        .idx_c   (rr_idx)
    );

    // Next enabled channel after ptr, used by strict-mode advance and skip.
    udma_i2s_rr_pick #(.N(NUM_CHANNELS)) u_en_pick (
        .req     (cfg_ch_en_i),
        .start   (start_idx),
        .found_c (en_found),
        .idx_c   (en_idx)
    );

    always_comb begin
        grant_any = 1'b0;
        grant_idx = ptr_q;
        if (mode == ARB_STRICT) begin
            grant_any = eligible[ptr_q];
        end else begin
            grant_any = rr_found;
            grant_idx = rr_idx;
        end
    end

    assign load       = can_load && grant_any && !soft_rst;
    assign ch_ready_o = load ? (NUM_CHANNELS'(1) << grant_idx) : '0;

    // Output register, pointer, timeout counter and sticky error next-state.
    always_comb begin
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        valid_d = valid_o;
        data_d  = data_o;
        ch_id_d = ch_id_o;
        err_d   = err_o & ~err_clr_i;

        if (load) begin
            valid_d = 1'b1;
            ch_id_d = grant_idx;
            data_d  = ch_data[grant_idx];
            if (cfg_tag_en_i) begin
                data_d[DATA_WIDTH-1 -: CH_ID_W] = grant_idx;
            end
        end else if (ready_i) begin
            valid_d = 1'b0;
        end

        if (mode == ARB_RR) begin
            cnt_d = '0;
            if (load) begin
                ptr_d = grant_idx;
            end
        end else if (load || !cfg_ch_en_i[ptr_q]) begin
            cnt_d = '0;
            if (en_found) begin
                ptr_d = en_idx;
            end
        end else if (can_load) begin
            // Expected channel enabled but silent while the output could accept.
            if (cfg_timeout_i != '0 && cnt_q == cfg_timeout_i - TIMEOUT_W'(1)) begin
                err_d[ptr_q] = 1'b1;
                ptr_d        = en_idx;
                cnt_d        = '0;
            end else begin
                cnt_d = cnt_q + TIMEOUT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (soft_rst) begin
            ptr_q   <= '0;
            cnt_q   <= '0;
            valid_o <= 1'b0;
            data_o  <= '0;
            ch_id_o <= '0;
            err_o   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            valid_o <= valid_d;
            data_o  <= data_d;
            ch_id_o <= ch_id_d;
            err_o   <= err_d;
        end
    end

endmodule

// File: tb/tb_udma_i2s_rx_arbiter.sv
// Scoreboard bench for udma_i2s_rx_arbiter: expected words queued by each scenario, popped on output handshake.
module tb_udma_i2s_rx_arbiter;

    localparam int unsigned NC = 2;
    localparam int unsigned DW = 32;
    localparam int unsigned TW = 16;

    typedef struct packed {
        logic [0:0]    id;
        logic [DW-1:0] data;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             clr_i;
    logic [NC*DW-1:0] ch_data_i;
    logic [NC-1:0]    ch_valid_i;
    logic [NC-1:0]    ch_ready_o;
    logic [DW-1:0]    data_o;
    logic             valid_o;
    logic             ready_i;
    logic [0:0]       ch_id_o;
    logic [NC-1:0]    cfg_ch_en_i;
    logic             cfg_strict_i;
    logic             cfg_tag_en_i;
    logic [TW-1:0]    cfg_timeout_i;
    logic [NC-1:0]    err_o;
    logic [NC-1:0]    err_clr_i;

    int          tests_run    = 0;
    int          tests_failed = 0;
    exp_t        sb_q [$];
    exp_t        mon_exp;
    int unsigned src_seq [NC];
    bit          use_seq;

    udma_i2s_rx_arbiter #(
        .NUM_CHANNELS (NC),
        .DATA_WIDTH   (DW),
        .TIMEOUT_W    (TW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .clr_i         (clr_i),
        .ch_data_i     (ch_data_i),
        .ch_valid_i    (ch_valid_i),
        .ch_ready_o    (ch_ready_o),
        .data_o        (data_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .ch_id_o       (ch_id_o),
        .cfg_ch_en_i   (cfg_ch_en_i),
        .cfg_strict_i  (cfg_strict_i),
        .cfg_tag_en_i  (cfg_tag_en_i),
        .cfg_timeout_i (cfg_timeout_i),
        .err_o         (err_o),
        .err_clr_i     (err_clr_i)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] word_of(input int unsigned ch, input int unsigned k);
        return DW'((ch << 16) | (k & 32'hFFFF));
    endfunction

    // Handshake monitor: pops the scoreboard and advances the source sequence numbers.
    always @(negedge clk) begin
        #3;
        if (!rst_i && !clr_i) begin
            if (valid_o && ready_i) begin
                tests_run++;
                if (sb_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL scoreboard_extra: got id=%0d data=%h, required no output", ch_id_o, data_o);
                end else begin
                    mon_exp = sb_q.pop_front();
                    if (data_o !== mon_exp.data || ch_id_o !== mon_exp.id) begin
                        tests_failed++;
                        $display("FAIL scoreboard: got id=%0d data=%h, required id=%0d data=%h",
                                 ch_id_o, data_o, mon_exp.id, mon_exp.data);
                    end
                end
            end
            tests_run++;
            if ($countones(ch_ready_o) > 1 || (valid_o && !ready_i && ch_ready_o != '0)) begin
                tests_failed++;
                $display("FAIL ready_invariant: got ch_ready=%b valid=%b ready=%b, required onehot0 and 0 under stall",
                         ch_ready_o, valid_o, ready_i);
            end
            for (int unsigned i = 0; i < NC; i++) begin
                if (ch_ready_o[i]) src_seq[i]++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (use_seq) begin
            for (int unsigned i = 0; i < NC; i++) ch_data_i[i*DW +: DW] = word_of(i, src_seq[i]);
        end
    endtask

    task automatic do_reset();
        rst_i         = 1'b1;
        clr_i         = 1'b0;
        ch_valid_i    = '0;
        cfg_ch_en_i   = '0;
        cfg_strict_i  = 1'b0;
        cfg_tag_en_i  = 1'b0;
        cfg_timeout_i = '0;
        err_clr_i     = '0;
        ready_i       = 1'b1;
        for (int unsigned i = 0; i < NC; i++) src_seq[i] = 0;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic check_drained(input string name);
        tests_run++;
        if (sb_q.size() != 0 || valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_drain: got %0d pending valid=%b, required 0 pending valid=0", name, sb_q.size(), valid_o);
        end
        sb_q.delete();
    endtask

    task automatic test_reset();
        use_seq       = 1'b1;
        rst_i         = 1'b1;
        clr_i         = 1'b0;
        cfg_ch_en_i   = 2'b11;
        ch_valid_i    = 2'b11;
        cfg_strict_i  = 1'b0;
        cfg_tag_en_i  = 1'b0;
        cfg_timeout_i = '0;
        err_clr_i     = '0;
        ready_i       = 1'b1;
        ch_data_i     = '1;
        tick();
        tests_run++;
        if (ch_ready_o !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_ch_ready: got %b, required 00", ch_ready_o);
        end
        tick();
        tests_run++;
        if (valid_o !== 1'b0 || data_o !== '0 || ch_id_o !== 1'b0 || err_o !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_state: got valid=%b data=%h id=%b err=%b, required 0 0 0 00",
                     valid_o, data_o, ch_id_o, err_o);
        end
        ch_valid_i = '0;
        rst_i      = 1'b0;
        tick();
    endtask

    task automatic test_rr_alternate();
        logic [0:0] exp_id;
        use_seq = 1'b1;
        do_reset();
        cfg_ch_en_i = 2'b11;
        ch_valid_i  = 2'b11;
        for (int unsigned k = 0; k < 5; k++) begin
            sb_q.push_back('{id: 1'b1, data: word_of(1, k)});
            sb_q.push_back('{id: 1'b0, data: word_of(0, k)});
        end
        #1;
        tests_run++;
        if (valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL rr_latency: got valid=%b before first edge, required 0", valid_o);
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            exp_id = ((c % 2) == 0) ? 1'b1 : 1'b0;
            tests_run++;
            if (valid_o !== 1'b1 || ch_id_o !== exp_id) begin
                tests_failed++;
                $display("FAIL rr_order: cycle %0d got valid=%b id=%0d, required valid=1 id=%0d", c, valid_o, ch_id_o, exp_id);
            end
        end
        ch_valid_i = '0;
        tick();
        tick();
        check_drained("rr");
    endtask

    task automatic test_backpressure();
        use_seq = 1'b0;
        do_reset();
        cfg_ch_en_i = 2'b01;
        ch_valid_i  = 2'b01;
        ch_data_i   = {32'h0, 32'hA5A5_0001};
        ready_i     = 1'b0;
        sb_q.push_back('{id: 1'b0, data: 32'hA5A5_0001});
        sb_q.push_back('{id: 1'b0, data: 32'hA5A5_0002});
        tick();
        ch_data_i = {32'h0, 32'hA5A5_0002};
        for (int c = 0; c < 5; c++) begin
            tick();
            tests_run++;
            if (valid_o !== 1'b1 || data_o !== 32'hA5A5_0001 || ch_ready_o !== 2'b00) begin
                tests_failed++;
                $display("FAIL bp_hold: cycle %0d got valid=%b data=%h ch_ready=%b, required 1 a5a50001 00",
                         c, valid_o, data_o, ch_ready_o);
            end
        end
        ready_i = 1'b1;
        tick();
        tests_run++;
        if (data_o !== 32'hA5A5_0002) begin
            tests_failed++;
            $display("FAIL bp_next: got %h, required a5a50002", data_o);
        end
        ch_valid_i = '0;
        tick();
        tick();
        check_drained("bp");
    endtask

    task automatic test_strict_order();
        logic [NC-1:0] exp_rdy;
        use_seq = 1'b1;
        do_reset();
        cfg_ch_en_i  = 2'b11;
        cfg_strict_i = 1'b1;
        for (int unsigned k = 0; k < 4; k++) begin
            sb_q.push_back('{id: 1'b0, data: word_of(0, k)});
            sb_q.push_back('{id: 1'b1, data: word_of(1, k)});
        end
        for (int c = 0; c < 16; c++) begin
            ch_valid_i = ((c % 4) == 3) ? 2'b11 : 2'b01;
            #1;
            exp_rdy = ((c % 4) == 0) ? 2'b01 : (((c % 4) == 3) ? 2'b10 : 2'b00);
            tests_run++;
            if (ch_ready_o !== exp_rdy) begin
                tests_failed++;
                $display("FAIL strict_ready: cycle %0d got %b, required %b", c, ch_ready_o, exp_rdy);
            end
            tick();
        end
        ch_valid_i = '0;
        tick();
        tick();
        check_drained("strict");
    endtask

    task automatic test_timeout();
        logic [NC-1:0] exp_rdy;
        use_seq = 1'b1;
        do_reset();
        cfg_ch_en_i   = 2'b11;
        cfg_strict_i  = 1'b1;
        cfg_timeout_i = TW'(8);
        ch_valid_i    = 2'b01;
        for (int unsigned k = 0; k < 3; k++) sb_q.push_back('{id: 1'b0, data: word_of(0, k)});
        for (int c = 0; c < 27; c++) begin
            #1;
            exp_rdy = ((c % 9) == 0) ? 2'b01 : 2'b00;
            tests_run++;
            if (ch_ready_o !== exp_rdy) begin
                tests_failed++;
                $display("FAIL timeout_ready: cycle %0d got %b, required %b", c, ch_ready_o, exp_rdy);
            end
            if (c == 8 || c == 9) begin
                tests_run++;
                if (err_o !== ((c == 9) ? 2'b10 : 2'b00)) begin
                    tests_failed++;
                    $display("FAIL timeout_err: cycle %0d got %b, required %b", c, err_o, (c == 9) ? 2'b10 : 2'b00);
                end
            end
            tick();
        end
        ch_valid_i    = '0;
        cfg_timeout_i = '0;
        tick();
        err_clr_i = 2'b10;
        tick();
        err_clr_i = 2'b00;
        tests_run++;
        if (err_o !== 2'b00) begin
            tests_failed++;
            $display("FAIL timeout_err_clr: got %b, required 00", err_o);
        end
        check_drained("timeout");
    endtask

    task automatic test_tag();
        use_seq = 1'b0;
        do_reset();
        cfg_ch_en_i  = 2'b11;
        cfg_tag_en_i = 1'b1;
        ch_data_i    = {32'h0000_1234, 32'hFFFF_0000};
        ch_valid_i   = 2'b11;
        sb_q.push_back('{id: 1'b1, data: 32'h8000_1234});
        sb_q.push_back('{id: 1'b0, data: 32'h7FFF_0000});
        tick();
        tests_run++;
        if (data_o !== 32'h8000_1234 || ch_id_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL tag_ch1: got data=%h id=%0d, required 80001234 id=1", data_o, ch_id_o);
        end
        tick();
        tests_run++;
        if (data_o !== 32'h7FFF_0000 || ch_id_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL tag_ch0: got data=%h id=%0d, required 7fff0000 id=0", data_o, ch_id_o);
        end
        ch_valid_i = '0;
        tick();
        tick();
        check_drained("tag");
    endtask

    task automatic test_clear();
        use_seq = 1'b0;
        do_reset();
        cfg_ch_en_i   = 2'b11;
        cfg_strict_i  = 1'b1;
        cfg_timeout_i = TW'(2);
        ch_data_i     = {32'h1111_0001, 32'h2222_0002};
        ch_valid_i    = 2'b01;
        sb_q.push_back('{id: 1'b0, data: 32'h2222_0002});
        tick();
        tick();
        tick();
        tests_run++;
        if (err_o !== 2'b10) begin
            tests_failed++;
            $display("FAIL clr_pre_err: got %b, required 10", err_o);
        end
        tick();
        ready_i = 1'b0;
        clr_i   = 1'b1;
        tick();
        clr_i = 1'b0;
        tests_run++;
        if (valid_o !== 1'b0 || err_o !== 2'b00 || data_o !== '0 || ch_id_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL clr_state: got valid=%b err=%b data=%h id=%b, required 0 00 0 0", valid_o, err_o, data_o, ch_id_o);
        end
        cfg_strict_i = 1'b0;
        ch_valid_i   = 2'b11;
        ready_i      = 1'b1;
        #1;
        tests_run++;
        if (ch_ready_o !== 2'b10) begin
            tests_failed++;
            $display("FAIL clr_restart: got ch_ready=%b, required 10", ch_ready_o);
        end
        sb_q.push_back('{id: 1'b1, data: 32'h1111_0001});
        sb_q.push_back('{id: 1'b0, data: 32'h2222_0002});
        tick();
        tick();
        ch_valid_i = '0;
        tick();
        tick();
        check_drained("clr");
    endtask

    initial begin
        test_reset();
        test_rr_alternate();
        test_backpressure();
        test_strict_order();
        test_timeout();
        test_tag();
        test_clear();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
